alu_sequencer: RTL and testbench

Issue and writeback controller that drives the ALU's operand/function inputs and consumes its result and flags. It accepts one register-register instruction per valid/ready handshake and reads both operands from the synchronous dual-port register file. It applies them to the combinational ALU, registers result and flags, then writes the result back. It sits between the instruction source and the ALU / register file in the RISC datapath.

---
 rtl/risc_pkg.sv | 36 +++
 rtl/seq_cond_eval.sv | 27 ++
 rtl/alu_sequencer.sv | 135 +++++++++++++
 tb/tb_alu_sequencer.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/risc_pkg.sv
// Shared definitions for the RISC datapath: ALU function codes, flag bit
// positions, sequencer states and condition codes.
// Ports: none (package).
package risc_pkg;

    typedef enum logic [2:0] {
        RA   = 3'd0,
        RB   = 3'd1,
        RADD = 3'd2,
        RSUB = 3'd3,
        RAND = 3'd4,
        ROR  = 3'd5,
        RXOR = 3'd6,
        RNOR = 3'd7
    } alu_func_e;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        EXEC  = 2'd2,
        WRITE = 2'd3
    } seq_state_e;

    typedef enum logic [1:0] {
        COND_AL = 2'd0,
        COND_Z  = 2'd1,
        COND_C  = 2'd2,
        COND_N  = 2'd3
    } cond_e;

endpackage

// File: rtl/seq_cond_eval.sv
// Maps a condition code and the current flags to an execute bit.
// Latency: combinational. Backpressure: none.
// Ports: cond (2b code), flags (N/Z/C/V), exec (1 = instruction takes effect).
module seq_cond_eval
    import risc_pkg::*;
(
    input  logic [1:0] cond,
    input  logic [3:0] flags,
    output logic       exec
);

    // Overflow is not a selectable condition.
    logic unused_v;
    assign unused_v = flags[FLAG_V];

    always_comb begin
        exec = 1'b1;
        case (cond_e'(cond))
            COND_AL: exec = 1'b1;
            COND_Z:  exec = flags[FLAG_Z];
            COND_C:  exec = flags[FLAG_C];
            COND_N:  exec = flags[FLAG_N];
            default: exec = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_sequencer.sv
// Issue/writeback controller: reads two RF operands, drives the ALU, writes the result back.
// Latency: accept edge to done/rf_we cycle is 3 cycles; one instruction per 4 cycles.
// Backpressure: instr_ready (registered) is high only in IDLE; optional COND_EXEC_EN build macro
// enables conditional execution against the previous instruction's flags.
// Ports: instr_* handshake/fields in, rf_* register-file read/write, alu_* operand/result,
// flags_q registered flags, done one-cycle retire pulse.
module alu_sequencer
    import risc_pkg::*;
#(
    parameter int n  = 8,
    parameter int AW = 3
) (
    input  logic          clk,
    input  logic          n_reset,
    input  logic          instr_valid,
    output logic          instr_ready,
    input  logic [2:0]    instr_func,
    input  logic [AW-1:0] instr_rd,
    input  logic [AW-1:0] instr_ra,
    input  logic [AW-1:0] instr_rb,
    input  logic [1:0]    instr_cond,
    output logic [AW-1:0] rf_raddr1,
    output logic [AW-1:0] rf_raddr2,
    input  logic [n-1:0]  rf_rdata1,
    input  logic [n-1:0]  rf_rdata2,
    output logic          rf_we,
    output logic [AW-1:0] rf_waddr,
    output logic [n-1:0]  rf_wdata,
    output logic [n-1:0]  alu_a,
    output logic [n-1:0]  alu_b,
    output logic [2:0]    alu_func,
    input  logic [n-1:0]  alu_result,
    input  logic [3:0]    alu_flags,
    output logic [3:0]    flags_q,
    output logic          done
);

    seq_state_e    state_q, state_d;
    logic [2:0]    func_q;
    logic [AW-1:0] rd_q, ra_q, rb_q;
    logic [n-1:0]  result_q;
    logic          accept;
    logic          exec_now;   // instruction in EXEC is allowed to take effect
    logic          wb_en;      // instruction in WRITE is allowed to write back

    assign accept = instr_valid && instr_ready && (state_q == IDLE);

`ifdef COND_EXEC_EN
    logic [1:0] cond_q;
    logic       cond_pass;
    logic       wb_q;

    seq_cond_eval u_cond (
        .cond  (cond_q),
        .flags (flags_q),
        .exec  (cond_pass)
    );

    // flags_q changes at the end of EXEC, so the verdict is captured there
    // rather than re-evaluated in WRITE.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            cond_q <= 2'd0;
            wb_q   <= 1'b0;
        end else begin
            if (accept)
                cond_q <= instr_cond;
            if (state_q == EXEC)
                wb_q <= cond_pass;
        end
    end

    assign exec_now = cond_pass;
    assign wb_en    = wb_q;
`else
    logic unused_cond;
    assign unused_cond = ^instr_cond;
    assign exec_now    = 1'b1;
    assign wb_en       = 1'b1;
`endif

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q     <= IDLE;
            instr_ready <= 1'b0;
            func_q      <= 3'd0;
            rd_q        <= '0;
            ra_q        <= '0;
            rb_q        <= '0;
            result_q    <= '0;
            flags_q     <= 4'd0;
        end else begin
            state_q     <= state_d;
            instr_ready <= (state_d == IDLE);
            if (accept) begin
                func_q <= instr_func;
                rd_q   <= instr_rd;
                ra_q   <= instr_ra;
                rb_q   <= instr_rb;
            end
            if ((state_q == EXEC) && exec_now) begin
                result_q <= alu_result;
                flags_q  <= alu_flags;
            end
        end
    end

    // rf_we is decoded from state only, so an asynchronous reset clears it
    // immediately and no partial write can happen.
    always_comb begin
        state_d = state_q;
        rf_we   = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE:  if (accept) state_d = READ;
            READ:  state_d = EXEC;
            EXEC:  state_d = WRITE;
            WRITE: begin
                rf_we   = wb_en;
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign rf_raddr1 = ra_q;
    assign rf_raddr2 = rb_q;
    assign rf_waddr  = rd_q;
    assign rf_wdata  = result_q;
    assign alu_a     = rf_rdata1;
    assign alu_b     = rf_rdata2;
    assign alu_func  = func_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: behavioural register file and ALU around the DUT,
// an instruction-level reference model checked every cycle, directed cases, random traffic.
module tb_alu_sequencer;
    import risc_pkg::*;

    localparam int N  = 8;
    localparam int AW = 3;

    logic          clk;
    logic          n_reset;
    logic          instr_valid;
    logic          instr_ready;
    logic [2:0]    instr_func;
    logic [AW-1:0] instr_rd, instr_ra, instr_rb;
    logic [1:0]    instr_cond;
    logic [AW-1:0] rf_raddr1, rf_raddr2, rf_waddr;
    logic [N-1:0]  rf_rdata1, rf_rdata2, rf_wdata;
    logic          rf_we;
    logic [N-1:0]  alu_a, alu_b, alu_result;
    logic [2:0]    alu_func;
    logic [3:0]    alu_flags, flags_q;
    logic          done;

    int n_cmp = 0;
    int n_bad = 0;
    int done_cnt = 0;
    int ncyc = 0;
    int acc_q[$];

    alu_sequencer #(.n(N), .AW(AW)) dut (
        .clk(clk), .n_reset(n_reset),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_func(instr_func), .instr_rd(instr_rd), .instr_ra(instr_ra),
        .instr_rb(instr_rb), .instr_cond(instr_cond),
        .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
        .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .alu_a(alu_a), .alu_b(alu_b), .alu_func(alu_func),
        .alu_result(alu_result), .alu_flags(alu_flags),
        .flags_q(flags_q), .done(done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [7:0] init_val(input int i);
        case (i)
            0: return 8'h11;
            1: return 8'h64;
            2: return 8'h32;
            3: return 8'h00;
            4: return 8'h5A;
            5: return 8'h00;
            6: return 8'hA5;
            default: return 8'h0F;
        endcase
    endfunction

    // ALU behaviour: returns {N,Z,C,V,result}. C on SUB means "no borrow".
    function automatic logic [11:0] alu_f(input logic [2:0] f, input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r;
        logic [8:0] s;
        logic       c, v;
        r = 8'd0; s = 9'd0; c = 1'b0; v = 1'b0;
        case (f)
            3'd0: r = a;
            3'd1: r = b;
            3'd2: begin
                s = {1'b0, a} + {1'b0, b};
                r = s[7:0]; c = s[8];
                v = (a[7] == b[7]) && (r[7] != a[7]);
            end
            3'd3: begin
                s = {1'b0, a} - {1'b0, b};
                r = s[7:0]; c = ~s[8];
                v = (a[7] != b[7]) && (r[7] != a[7]);
            end
            3'd4: r = a & b;
            3'd5: r = a | b;
            3'd6: r = a ^ b;
            default: r = ~(a | b);
        endcase
        return {r[7], (r == 8'd0), c, v, r};
    endfunction

    function automatic logic cond_ok(input logic [1:0] cd, input logic [3:0] fl);
`ifdef COND_EXEC_EN
        case (cd)
            2'd0: return 1'b1;
            2'd1: return fl[2];
            2'd2: return fl[1];
            default: return fl[3];
        endcase
`else
        return (cd == cd) || (fl == fl);
`endif
    endfunction

    always_comb {alu_flags, alu_result} = alu_f(alu_func, alu_a, alu_b);

    // Synchronous dual-port register file.
    logic [7:0] mem [8];
    initial begin
        for (int i = 0; i < 8; i++) mem[i] = init_val(i);
        rf_rdata1 = 8'd0;
        rf_rdata2 = 8'd0;
        forever begin
            @(posedge clk);
            rf_rdata1 <= mem[rf_raddr1];
            rf_rdata2 <= mem[rf_raddr2];
            if (rf_we) mem[rf_waddr] <= rf_wdata;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Instruction-level reference model; compared against the DUT every cycle.
    logic [7:0] arch [8];
    logic [3:0] m_flags, p_flags;
    logic [7:0] p_res;
    logic [2:0] p_rd;
    logic       m_ready, m_busy, m_ok;
    int         age;
    initial begin
        for (int i = 0; i < 8; i++) arch[i] = init_val(i);
        m_flags = 4'd0; m_ready = 1'b0; m_busy = 1'b0; m_ok = 1'b0; age = 0;
        p_flags = 4'd0; p_res = 8'd0; p_rd = 3'd0;
        forever begin
            @(negedge clk);
            ncyc++;
            if (done === 1'b1) done_cnt++;
            if (!n_reset) begin
                m_ready = 1'b0; m_busy = 1'b0; m_flags = 4'd0; age = 0;
                chk("rst_ready", 32'(instr_ready), 32'd0);
                chk("rst_we",    32'(rf_we),       32'd0);
                chk("rst_done",  32'(done),        32'd0);
                chk("rst_flags", 32'(flags_q),     32'd0);
            end else begin
                chk("ready", 32'(instr_ready), 32'(m_ready));
                chk("we",    32'(rf_we),       32'(m_busy && age == 3 && m_ok));
                chk("done",  32'(done),        32'(m_busy && age == 3));
                chk("flags", 32'(flags_q),     32'(m_flags));
                if (m_busy && age == 3 && m_ok) begin
                    chk("waddr", 32'(rf_waddr), 32'(p_rd));
                    chk("wdata", 32'(rf_wdata), 32'(p_res));
                end
                if (instr_valid && instr_ready) acc_q.push_back(ncyc);
                // advance to the next edge
                if (m_busy) begin
                    age++;
                    if (age == 3 && m_ok) m_flags = p_flags;
                    if (age == 4) begin
                        if (m_ok) arch[p_rd] = p_res;
                        m_busy  = 1'b0;
                        m_ready = 1'b1;
                    end
                end else if (m_ready && instr_valid) begin
                    {p_flags, p_res} = alu_f(instr_func, arch[instr_ra], arch[instr_rb]);
                    p_rd    = instr_rd;
                    m_ok    = cond_ok(instr_cond, m_flags);
                    m_busy  = 1'b1;
                    m_ready = 1'b0;
                    age     = 1;
                end else begin
                    m_ready = 1'b1;
                end
            end
        end
    end

    task automatic garbage();
        instr_func = 3'($urandom); instr_rd = 3'($urandom);
        instr_ra = 3'($urandom); instr_rb = 3'($urandom); instr_cond = 2'($urandom);
    endtask

    task automatic wait_ready();
        int w;
        w = 0;
        while (!instr_ready && w < 20) begin
            @(posedge clk); #2;
            w++;
        end
        chk("ready_timeout", 32'(instr_ready), 32'd1);
    endtask

    // Called at posedge+2; returns at posedge+2 just after the accept edge.
    task automatic issue(input logic [2:0] f, input logic [2:0] rd, input logic [2:0] ra,
                         input logic [2:0] rb, input logic [1:0] cd);
        wait_ready();
        instr_func = f; instr_rd = rd; instr_ra = ra; instr_rb = rb; instr_cond = cd;
        instr_valid = 1'b1;
        @(posedge clk); #2;
        instr_valid = 1'b0;
        garbage();
    endtask

    initial begin
        int d0, a0;
        n_reset = 1'b0; instr_valid = 1'b0;
        instr_func = 3'd0; instr_rd = 3'd0; instr_ra = 3'd0; instr_rb = 3'd0; instr_cond = 2'd0;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_lit_ready", 32'(instr_ready), 32'd0);
        chk("rst_lit_we",    32'(rf_we),       32'd0);
        chk("rst_lit_done",  32'(done),        32'd0);
        chk("rst_lit_flags", 32'(flags_q),     32'd0);
        chk("rst_lit_raddr", 32'(rf_raddr1),   32'd0);
        chk("rst_lit_wdata", 32'(rf_wdata),    32'd0);
        chk("rst_lit_func",  32'(alu_func),    32'd0);
        #1 n_reset = 1'b1;
        #1 chk("ready_before_edge", 32'(instr_ready), 32'd0);
        @(posedge clk); #1;
        chk("ready_one_edge", 32'(instr_ready), 32'd1);
        #1;

        // RADD r3 = r1 + r2
        d0 = done_cnt;
        issue(3'd2, 3'd3, 3'd1, 3'd2, 2'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("radd_we",    32'(rf_we),    32'd1);
        chk("radd_waddr", 32'(rf_waddr), 32'd3);
        chk("radd_wdata", 32'(rf_wdata), 32'h96);
        chk("radd_done",  32'(done),     32'd1);
        #1;
        wait_ready();
        chk("radd_mem",   32'(mem[3]),  32'h96);
        chk("radd_model", 32'(arch[3]), 32'h96);
        chk("radd_done_once", 32'(done_cnt - d0), 32'd1);

        // RSUB r4 = r1 - r1 -> zero
        issue(3'd3, 3'd4, 3'd1, 3'd1, 2'd0);
        wait_ready();
        chk("rsub_mem",   32'(mem[4]),     32'h00);
        chk("rsub_z",     32'(flags_q[2]), 32'd1);
        chk("rsub_flags", 32'(flags_q),    32'h6);

        // RB r5 = r2
        issue(3'd1, 3'd5, 3'd0, 3'd2, 2'd0);
        wait_ready();
        chk("rb_mem", 32'(mem[5]),     32'h32);
        chk("rb_z",   32'(flags_q[2]), 32'd0);

        // Back-to-back: RXOR r7 = r1^r2, then RAND r3 = r7 & r1 (reads the fresh r7)
        a0 = acc_q.size();
        instr_func = 3'd6; instr_rd = 3'd7; instr_ra = 3'd1; instr_rb = 3'd2; instr_cond = 2'd0;
        instr_valid = 1'b1;
        wait_ready();
        @(posedge clk); #2;
        instr_func = 3'd4; instr_rd = 3'd3; instr_ra = 3'd7; instr_rb = 3'd1;
        wait_ready();
        @(posedge clk); #2;
        instr_valid = 1'b0;
        garbage();
        chk("b2b_count", 32'(acc_q.size() - a0), 32'd2);
        if (acc_q.size() >= a0 + 2)
            chk("b2b_gap", 32'(acc_q[a0+1] - acc_q[a0]), 32'd4);
        wait_ready();
        chk("b2b_xor", 32'(mem[7]), 32'h56);
        chk("b2b_and", 32'(mem[3]), 32'h44);

        // Reset during EXEC of RADD r6
        issue(3'd2, 3'd6, 3'd1, 3'd2, 2'd0);
        @(posedge clk); #2;
        n_reset = 1'b0;
        #1 chk("rst_async_we", 32'(rf_we), 32'd0);
        @(posedge clk); #2;
        n_reset = 1'b1;
        wait_ready();
        repeat (3) @(posedge clk);
        #2;
        chk("rst_r6_kept", 32'(mem[6]), 32'hA5);
        issue(3'd2, 3'd6, 3'd1, 3'd2, 2'd0);
        wait_ready();
        chk("after_rst_r6", 32'(mem[6]), 32'h96);

`ifdef COND_EXEC_EN
        issue(3'd3, 3'd4, 3'd1, 3'd1, 2'd0);
        wait_ready();
        issue(3'd2, 3'd0, 3'd1, 3'd2, 2'd1);
        wait_ready();
        chk("cond_z_taken", 32'(mem[0]), 32'h96);
        chk("cond_flags1",  32'(flags_q), 32'h9);
        d0 = done_cnt;
        issue(3'd2, 3'd5, 3'd1, 3'd1, 2'd1);
        wait_ready();
        chk("cond_skip_mem",   32'(mem[5]), 32'h32);
        chk("cond_skip_flags", 32'(flags_q), 32'h9);
        chk("cond_skip_done",  32'(done_cnt - d0), 32'd1);
`endif

        // Random traffic
        for (int k = 0; k < 150; k++) begin
            int gap;
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) begin
                garbage();
                @(posedge clk); #2;
            end
            issue(3'($urandom), 3'($urandom), 3'($urandom), 3'($urandom), 2'($urandom));
        end
        wait_ready();
        @(posedge clk); #2;
        for (int i = 0; i < 8; i++)
            chk("final_reg", 32'(mem[i]), 32'(arch[i]));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
